// File: rtl/display_scan_capture_pkg.sv
// Shared constants for 7-segment scan decoding: glyph set, anode selects and capture FSM states.
package display_pkg;

    // Active-high segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [3:0] SEL_D0   = 4'b1110;
    localparam logic [3:0] SEL_D1   = 4'b1101;
    localparam logic [3:0] SEL_D2   = 4'b1011;
    localparam logic [3:0] SEL_D3   = 4'b0111;
    localparam logic [3:0] SEL_NONE = 4'b1111;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLING = 2'd1,
        SAMPLED  = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  code_err;
    } frame_t;

    // Returns {valid, digit index}; valid only when exactly one anode is driven low.
    function automatic logic [2:0] sel_lookup(input logic [3:0] sel);
        case (sel)
            SEL_D0:  return 3'b100;
            SEL_D1:  return 3'b101;
            SEL_D2:  return 3'b110;
            SEL_D3:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/display_scan_capture_seg7_to_hex.sv
// Combinational 7-segment (active-high g..a) to hex nibble decoder.
// Unknown patterns, including all segments off, decode to 0 with invalid set.
module seg7_to_hex
    import display_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_invalid
);

    always_comb begin
        o_nibble  = 4'h0;
        o_invalid = 1'b0;
        case (i_pattern)
            GLYPH_0: o_nibble = 4'h0;
            GLYPH_1: o_nibble = 4'h1;
            GLYPH_2: o_nibble = 4'h2;
            GLYPH_3: o_nibble = 4'h3;
            GLYPH_4: o_nibble = 4'h4;
            GLYPH_5: o_nibble = 4'h5;
            GLYPH_6: o_nibble = 4'h6;
            GLYPH_7: o_nibble = 4'h7;
            GLYPH_8: o_nibble = 4'h8;
            GLYPH_9: o_nibble = 4'h9;
            GLYPH_A: o_nibble = 4'hA;
            GLYPH_B: o_nibble = 4'hB;
            GLYPH_C: o_nibble = 4'hC;
            GLYPH_D: o_nibble = 4'hD;
            GLYPH_E: o_nibble = 4'hE;
            GLYPH_F: o_nibble = 4'hF;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_scan_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment scan and publishes 4-digit frames.
// Build option DISPLAY_SCAN_CAPTURE_CHANGE_ONLY_EN: strobe only frames that differ from the published ones.
module display_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sel_display,
    input  logic [7:0]  display,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  code_err,
    output logic        frame_valid,
    output logic        sel_err,
    output logic        scan_lost
);
    import display_pkg::*;

    localparam logic [CNT_W-1:0] SETTLE_LAST    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               SAMPLE_ON_LOAD = (SETTLE_CYCLES <= 1);

    scan_state_t      r_state;
    logic [11:0]      r_snap;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] r_timeout;
    logic [15:0]      r_pend_nib;
    logic [3:0]       r_pend_dp;
    logic [3:0]       r_pend_err;
    logic [3:0]       r_seen;

    logic [11:0]      w_cur;
    logic             w_match;
    logic             w_sel_valid;
    logic             w_sel_multi;
    logic [1:0]       w_sel_idx;
    logic [3:0]       w_nib;
    logic             w_invalid;
    logic [CNT_W-1:0] w_settle_inc;
    logic [CNT_W-1:0] w_timeout_inc;
    logic             w_settle_done;
    logic             w_load;
    logic             w_sample;
    logic             w_timeout_hit;
    logic             w_complete;
    logic             w_publish;
    logic [3:0]       w_seen_next;
    frame_t           w_frame;

    assign w_cur                    = {sel_display, display};
    assign w_match                  = (w_cur == r_snap);
    assign {w_sel_valid, w_sel_idx} = sel_lookup(sel_display);
    assign w_sel_multi              = !w_sel_valid && (sel_display != SEL_NONE);
    assign w_settle_inc             = r_settle + CNT_W'(1);
    assign w_timeout_inc            = r_timeout + CNT_W'(1);
    assign w_settle_done            = (w_settle_inc >= SETTLE_LAST);
    assign w_complete               = (r_seen == 4'hF);
    assign w_frame                  = '{digits: r_pend_nib, dp: r_pend_dp, code_err: r_pend_err};

    seg7_to_hex u_decode (
        .i_pattern (~display[6:0]),
        .o_nibble  (w_nib),
        .o_invalid (w_invalid)
    );

    // A load starts a new dwell; its own cycle counts as the first identical cycle.
    always_comb begin
        w_load   = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            WAIT_SEL: w_load = w_sel_valid;
            SETTLING: begin
                if (!w_match) begin
                    w_load = w_sel_valid;
                end else begin
                    w_sample = w_settle_done;
                end
            end
            SAMPLED:  w_load = !w_match && w_sel_valid;
            default:  w_load = 1'b0;
        endcase
        if (w_load && SAMPLE_ON_LOAD) begin
            w_sample = 1'b1;
        end
    end

    assign w_timeout_hit = !w_sample && (r_timeout != TIMEOUT_VAL) && (w_timeout_inc == TIMEOUT_VAL);

    // A sample in the completion cycle lands in the freshly cleared mask.
    always_comb begin
        w_seen_next = w_complete ? 4'h0 : r_seen;
        if (w_sample) begin
            w_seen_next = w_seen_next | (4'b0001 << w_sel_idx);
        end else if (w_timeout_hit) begin
            w_seen_next = 4'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= WAIT_SEL;
            r_snap   <= '0;
            r_settle <= '0;
        end else if (w_load) begin
            r_snap   <= w_cur;
            r_settle <= '0;
            r_state  <= w_sample ? SAMPLED : SETTLING;
        end else if ((r_state != WAIT_SEL) && !w_match) begin
            r_snap   <= w_cur;
            r_settle <= '0;
            r_state  <= WAIT_SEL;
        end else if (r_state == SETTLING) begin
            if (w_sample) begin
                r_state <= SAMPLED;
            end else begin
                r_settle <= w_settle_inc;
            end
        end
    end

`ifdef DISPLAY_SCAN_CAPTURE_CHANGE_ONLY_EN
    logic r_first;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b1;
        end else if (w_publish) begin
            r_first <= 1'b0;
        end
    end

    assign w_publish = w_complete && (r_first || (w_frame != frame_t'({digits, dp, code_err})));
`else
    assign w_publish = w_complete;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_nib  <= '0;
            r_pend_dp   <= '0;
            r_pend_err  <= '0;
            r_seen      <= '0;
            r_timeout   <= '0;
            digits      <= '0;
            dp          <= '0;
            code_err    <= '0;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
            scan_lost   <= 1'b0;
        end else begin
            frame_valid <= w_publish;
            if (w_publish) begin
                {digits, dp, code_err} <= w_frame;
            end
            r_seen <= w_seen_next;
            if (w_sel_multi) begin
                sel_err <= 1'b1;
            end else if (w_complete) begin
                sel_err <= 1'b0;
            end
            if (w_sample) begin
                r_pend_nib[{w_sel_idx, 2'b00} +: 4] <= w_nib;
                r_pend_dp[w_sel_idx]                <= ~display[7];
                r_pend_err[w_sel_idx]               <= w_invalid;
                r_timeout                           <= '0;
                scan_lost                           <= 1'b0;
            end else if (r_timeout != TIMEOUT_VAL) begin
                r_timeout <= w_timeout_inc;
                if (w_timeout_hit) begin
                    scan_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scan_capture.sv
// Self-checking bench for display_scan_capture: directed scans plus randomized dwells against a run-length model.
module tb_display_scan_capture;

    localparam int SETTLE = 4;
    localparam int TMO    = 4096;
`ifdef DISPLAY_SCAN_CAPTURE_CHANGE_ONLY_EN
    localparam bit CHANGE_ONLY = 1'b1;
`else
    localparam bit CHANGE_ONLY = 1'b0;
`endif
    localparam int EXP_DUP = CHANGE_ONLY ? 1 : 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sel_display = 4'hF;
    logic [7:0]  display = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  code_err;
    logic        frame_valid;
    logic        sel_err;
    logic        scan_lost;

    display_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel_display (sel_display),
        .display     (display),
        .digits      (digits),
        .dp          (dp),
        .code_err    (code_err),
        .frame_valid (frame_valid),
        .sel_err     (sel_err),
        .scan_lost   (scan_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Active-high g..a patterns for hex 0..F
    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [11:0] m_prev;
    int          m_run;
    int          m_since;
    logic [3:0]  m_seen;
    logic [15:0] m_pnib;
    logic [3:0]  m_pdp, m_perr;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_err;
    logic        m_fv, m_selerr, m_lost, m_first;

    int          diff_cycles = 0;
    int          dut_frames = 0;
    int          mdl_frames = 0;
    logic [26:0] first_obs, first_exp;

    function automatic logic [4:0] mdl_decode(input logic [6:0] pat);
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == pat) return {1'b0, 4'(i)};
        end
        return 5'b1_0000;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_since = 0; m_seen = '0;
        m_pnib = '0; m_pdp = '0; m_perr = '0;
        m_dig = '0; m_dp = '0; m_err = '0;
        m_fv = 1'b0; m_selerr = 1'b0; m_lost = 1'b0; m_first = 1'b1;
    endtask

    // One clock edge of the reference: sample when a valid select has been steady SETTLE cycles.
    task automatic model_edge(input logic [3:0] s, input logic [7:0] d);
        logic [11:0] cur;
        logic        valid, multi, samp, complete;
        logic [4:0]  dec;
        int          idx;
        cur = {s, d};
        if (m_run == 0 || cur != m_prev) m_run = 1;
        else if (m_run < 1000) m_run++;
        m_prev   = cur;
        valid    = ($countones(~s) == 1);
        multi    = ($countones(~s) > 1);
        samp     = valid && (m_run == SETTLE);
        complete = (m_seen == 4'hF);
        m_fv     = 1'b0;
        if (complete) begin
            if (!CHANGE_ONLY || m_first || ({m_pnib, m_pdp, m_perr} != {m_dig, m_dp, m_err})) begin
                m_dig = m_pnib; m_dp = m_pdp; m_err = m_perr;
                m_fv = 1'b1; m_first = 1'b0;
            end
            m_seen = '0;
            m_selerr = 1'b0;
        end
        if (multi) m_selerr = 1'b1;
        if (samp) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!s[i]) idx = i;
            dec = mdl_decode(~d[6:0]);
            m_pnib[4*idx +: 4] = dec[3:0];
            m_pdp[idx]  = ~d[7];
            m_perr[idx] = dec[4];
            m_seen[idx] = 1'b1;
            m_since = 0;
            m_lost  = 1'b0;
        end else if (m_since < TMO) begin
            m_since++;
            if (m_since == TMO) begin
                m_lost = 1'b1;
                m_seen = '0;
            end
        end
    endtask

    // Called at a falling edge; drives one cycle, advances the model and logs the observed outputs.
    task automatic step(input logic [3:0] s, input logic [7:0] d);
        logic [26:0] obs, expv;
        sel_display = s;
        display     = d;
        @(posedge clk);
        model_edge(s, d);
        #1;
        if (frame_valid) begin
            dut_frames++;
            $display("frame t=%0t digits=%h dp=%b code_err=%b sel_err=%b", $time, digits, dp, code_err, sel_err);
        end
        if (m_fv) mdl_frames++;
        obs  = {digits, dp, code_err, frame_valid, sel_err, scan_lost};
        expv = {m_dig, m_dp, m_err, m_fv, m_selerr, m_lost};
        if (obs !== expv) begin
            if (diff_cycles == 0) begin
                first_obs = obs;
                first_exp = expv;
            end
            diff_cycles++;
        end
        @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] d3, input logic [7:0] d2, input logic [7:0] d1,
                         input logic [7:0] d0, input int hold);
        repeat (hold) step(4'b0111, d3);
        repeat (hold) step(4'b1011, d2);
        repeat (hold) step(4'b1101, d1);
        repeat (hold) step(4'b1110, d0);
        repeat (2) step(4'b1111, 8'hFF);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits got %h want 0", digits); end
        checks++; if (dp !== 4'h0) begin errors++; $display("FAIL reset_dp got %b want 0", dp); end
        checks++; if (code_err !== 4'h0) begin errors++; $display("FAIL reset_code_err got %b want 0", code_err); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL reset_scan_lost got %b want 0", scan_lost); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_scan();
        int f0 = dut_frames;
        scan4(8'hB0, 8'hA4, 8'hF9, 8'hC0, 8);
        checks++; if (dut_frames - f0 !== 1) begin errors++; $display("FAIL basic_frames got %0d want 1", dut_frames - f0); end
        checks++; if (digits !== 16'h3210) begin errors++; $display("FAIL basic_digits got %h want 3210", digits); end
        checks++; if (dp !== 4'b0000) begin errors++; $display("FAIL basic_dp got %b want 0000", dp); end
        checks++; if (code_err !== 4'b0000) begin errors++; $display("FAIL basic_code_err got %b want 0000", code_err); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL basic_sel_err got %b want 0", sel_err); end
    endtask

    task automatic test_short_hold();
        int f0 = dut_frames;
        scan4(8'h8E, 8'h86, 8'hA1, 8'hC6, SETTLE - 1);
        checks++; if (dut_frames - f0 !== 0) begin errors++; $display("FAIL short_frames got %0d want 0", dut_frames - f0); end
        scan4(8'h8E, 8'h86, 8'hA1, 8'hC6, SETTLE);
        checks++; if (dut_frames - f0 !== 1) begin errors++; $display("FAIL settle_frames got %0d want 1", dut_frames - f0); end
        checks++; if (digits !== 16'hFEDC) begin errors++; $display("FAIL settle_digits got %h want fedc", digits); end
    endtask

    task automatic test_bad_glyph();
        scan4(8'hB0, 8'h7F, 8'hF9, 8'hC0, 8);
        checks++; if (digits !== 16'h3010) begin errors++; $display("FAIL glyph_digits got %h want 3010", digits); end
        checks++; if (code_err !== 4'b0100) begin errors++; $display("FAIL glyph_code_err got %b want 0100", code_err); end
        checks++; if (dp !== 4'b0100) begin errors++; $display("FAIL glyph_dp got %b want 0100", dp); end
    endtask

    task automatic test_sel_err();
        int f0 = dut_frames;
        repeat (8) step(4'b0111, 8'hB0);
        step(4'b1100, 8'hB0);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_set got %b want 1", sel_err); end
        repeat (8) step(4'b1011, 8'hA4);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_sticky got %b want 1", sel_err); end
        repeat (8) step(4'b1101, 8'hF9);
        repeat (8) step(4'b1110, 8'hC0);
        repeat (2) step(4'b1111, 8'hFF);
        checks++; if (dut_frames - f0 !== 1) begin errors++; $display("FAIL selerr_frames got %0d want 1", dut_frames - f0); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_clear got %b want 0", sel_err); end
        checks++; if (digits !== 16'h3210) begin errors++; $display("FAIL selerr_digits got %h want 3210", digits); end
    endtask

    task automatic test_timeout();
        int f0;
        int first_rise = -1;
        repeat (8) step(4'b0111, 8'hB0);
        for (int k = 1; k <= TMO; k++) begin
            step(4'b1111, 8'hFF);
            if (scan_lost && first_rise < 0) first_rise = k;
        end
        checks++; if (first_rise !== TMO - 4) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", first_rise, TMO - 4); end
        repeat (3) step(4'b1111, 8'hFF);
        checks++; if (scan_lost !== 1'b1) begin errors++; $display("FAIL timeout_level got %b want 1", scan_lost); end
        f0 = dut_frames;
        repeat (8) step(4'b1011, 8'h90);
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", scan_lost); end
        repeat (8) step(4'b1101, 8'h88);
        repeat (8) step(4'b1110, 8'h83);
        repeat (2) step(4'b1111, 8'hFF);
        checks++; if (dut_frames - f0 !== 0) begin errors++; $display("FAIL timeout_partial got %0d frames want 0", dut_frames - f0); end
        scan4(8'h99, 8'h90, 8'h88, 8'h83, 8);
        checks++; if (dut_frames - f0 !== 1) begin errors++; $display("FAIL timeout_resume got %0d frames want 1", dut_frames - f0); end
        checks++; if (digits !== 16'h49AB) begin errors++; $display("FAIL timeout_digits got %h want 49ab", digits); end
    endtask

    task automatic test_reset_mid();
        int f0;
        repeat (8) step(4'b0111, 8'h92);
        repeat (8) step(4'b1011, 8'h82);
        repeat (2) step(4'b1101, 8'hF8);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if ({digits, dp, code_err} !== 24'h0) begin errors++; $display("FAIL midreset_frame got %h want 0", {digits, dp, code_err}); end
        checks++; if ({frame_valid, sel_err, scan_lost} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b want 000", {frame_valid, sel_err, scan_lost}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        f0 = dut_frames;
        repeat (8) step(4'b1101, 8'hF8);
        repeat (8) step(4'b1110, 8'h80);
        repeat (2) step(4'b1111, 8'hFF);
        checks++; if (dut_frames - f0 !== 0) begin errors++; $display("FAIL midreset_stale got %0d frames want 0", dut_frames - f0); end
        scan4(8'h92, 8'h82, 8'hF8, 8'h80, 8);
        scan4(8'h92, 8'h82, 8'hF8, 8'h80, 8);
        checks++; if (dut_frames - f0 !== EXP_DUP) begin errors++; $display("FAIL back_to_back got %0d frames want %0d", dut_frames - f0, EXP_DUP); end
        checks++; if (digits !== 16'h5678) begin errors++; $display("FAIL midreset_digits got %h want 5678", digits); end
    endtask

    task automatic test_random();
        int          m0 = mdl_frames;
        int          f0 = dut_frames;
        logic [3:0]  s;
        logic [7:0]  d;
        logic [3:0]  onehot;
        int          r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                s = 4'hF;
            end else if (r == 1) begin
                s = 4'($urandom_range(0, 15));
                while ($countones(~s) < 2) s = 4'($urandom_range(0, 15));
            end else begin
                onehot = 4'b1000 >> (r < 16 ? (n % 4) : $urandom_range(0, 3));
                s = ~onehot;
            end
            if ($urandom_range(0, 7) == 0) d = 8'($urandom);
            else d = {1'($urandom_range(0, 1)), ~glyphs[$urandom_range(0, 15)]};
            repeat ($urandom_range(1, 7)) step(s, d);
        end
        repeat (2) step(4'b1111, 8'hFF);
        checks++; if (dut_frames - f0 !== mdl_frames - m0) begin errors++; $display("FAIL random_frames got %0d want %0d", dut_frames - f0, mdl_frames - m0); end
        checks++; if (mdl_frames - m0 < 1) begin errors++; $display("FAIL random_coverage got %0d model frames want >0", mdl_frames - m0); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_short_hold();
        test_bad_glyph();
        test_sel_err();
        test_timeout();
        test_random();
        test_reset_mid();
        checks++;
        if (diff_cycles !== 0) begin
            errors++;
            $display("FAIL cycle_trace got %0d diverging cycles, first got %h want %h", diff_cycles, first_obs, first_exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
